// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among NUM_REQ sources.
// Define UART_ARB_TAG_EN to prefix a tag byte (8'hA0|id) whenever the source changes.
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int TIMEOUT    = 64,
  parameter int GAP_CYCLES = 16
) (
  input  logic                 sys_clk,
  input  logic                 sys_rstn,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_int,
  input  logic                 tx_busy,
  output logic [2:0]           cur_id,
  output logic                 arb_busy,
  output logic                 timeout_err
);

  localparam int CMAX = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    IDLE, TAG, LAUNCH, WAIT_BUSY, WAIT_DONE, GAP
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2:0]         rr_q, rr_d;
  logic [2:0]         id_q, id_d;
  logic [7:0]         data_q, data_d;
  logic [NUM_REQ-1:0] rdy_q, rdy_d;
  logic               err_q, err_d;
`ifdef UART_ARB_TAG_EN
  logic               tag_q, tag_d;
  logic               seen_q, seen_d;
  logic [2:0]         last_q, last_d;
`endif

  logic [NUM_REQ-1:0] rot;
  logic [2:0]         gnt_id;
  logic [7:0]         gnt_byte;
  logic               gnt_vld;
  logic               busy_w;

  // X or Z on tx_busy must never look like a busy transmitter
  assign busy_w = (tx_busy === 1'b1);

  function automatic logic [2:0] wrap(input logic [2:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return 3'(s);
  endfunction

  always_comb begin
    rot     = NUM_REQ'({req_valid, req_valid} >> rr_q);
    gnt_vld = 1'b0;
    gnt_id  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        gnt_vld = 1'b1;
        gnt_id  = wrap(rr_q, k);
      end
    end
  end

  always_comb begin
    gnt_byte = 8'h00;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (3'(j) == gnt_id) gnt_byte = req_data[8*j +: 8];
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rr_q    <= '0;
      id_q    <= '0;
      data_q  <= 8'h00;
      rdy_q   <= '0;
      err_q   <= 1'b0;
`ifdef UART_ARB_TAG_EN
      tag_q   <= 1'b0;
      seen_q  <= 1'b0;
      last_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      data_q  <= data_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
`ifdef UART_ARB_TAG_EN
      tag_q   <= tag_d;
      seen_q  <= seen_d;
      last_q  <= last_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    id_d    = id_q;
    data_d  = data_q;
    rdy_d   = '0;
    err_d   = err_q;
`ifdef UART_ARB_TAG_EN
    tag_d   = tag_q;
    seen_d  = seen_q;
    last_d  = last_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          data_d  = gnt_byte;
          id_d    = gnt_id;
          rdy_d   = NUM_REQ'(1) << gnt_id;
          rr_d    = wrap(gnt_id, 1);
          cnt_d   = '0;
          state_d = LAUNCH;
`ifdef UART_ARB_TAG_EN
          seen_d  = 1'b1;
          last_d  = gnt_id;
          if (!seen_q || last_q != gnt_id) begin
            tag_d   = 1'b1;
            state_d = TAG;
          end
`endif
        end
      end
      TAG: begin
        cnt_d   = '0;
        state_d = LAUNCH;
      end
      LAUNCH: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(1)) begin
          cnt_d   = '0;
          state_d = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        cnt_d = cnt_q + CW'(1);
        if (busy_w) begin
          cnt_d   = '0;
          state_d = WAIT_DONE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          cnt_d   = '0;
          err_d   = 1'b1;
          state_d = GAP;
`ifdef UART_ARB_TAG_EN
          tag_d   = 1'b0;
`endif
        end
      end
      WAIT_DONE: begin
        if (!busy_w) begin
          cnt_d   = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(GAP_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = IDLE;
`ifdef UART_ARB_TAG_EN
          if (tag_q) begin
            tag_d   = 1'b0;
            state_d = LAUNCH;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_int      = (state_q != LAUNCH);
    arb_busy    = (state_q != IDLE);
    req_ready   = rdy_q;
    cur_id      = id_q;
    timeout_err = err_q;
    tx_data     = data_q;
`ifdef UART_ARB_TAG_EN
    if (tag_q) tx_data = 8'hA0 | {5'b00000, id_q};
`endif
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: table, hand-written and random checks of uart_tx_arbiter.
// Honours UART_ARB_TAG_EN the same way as the design.
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int TO  = 64;
  localparam int GAP = 16;

  logic           sys_clk = 1'b0;
  logic           sys_rstn = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic [7:0]     tx_data;
  logic           tx_int;
  logic           tx_busy = 1'b0;
  logic [2:0]     cur_id;
  logic           arb_busy;
  logic           timeout_err;

  always #5 sys_clk = ~sys_clk;

  uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT(TO), .GAP_CYCLES(GAP)) dut (
    .sys_clk(sys_clk), .sys_rstn(sys_rstn),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .tx_data(tx_data), .tx_int(tx_int), .tx_busy(tx_busy),
    .cur_id(cur_id), .arb_busy(arb_busy), .timeout_err(timeout_err)
  );

  typedef struct { logic [7:0] b; int id; bit tag; } ent_t;
  typedef struct { logic [3:0] valid; int n; int ids[4]; } vec_t;

  int errors = 0;
  int checks = 0;

  logic [7:0] rq [N][$];
  ent_t       exp_q[$];
  logic [7:0] sent_log[$];
  int         ack_log[$];
  int  mptr, last_id, t_busy, lat, frm, since_fall, low_run, cyc;
  int  rise_cyc, err_cyc;
  bit  seen, tie0, rnd_busy;
  logic       prev_int;
  logic [N-1:0] prev_rdy;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic check_ok(input string name, input bit ok,
                          input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic bit all_empty();
    for (int i = 0; i < N; i++)
      if (rq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = (rq[i].size() != 0);
      req_data[8*i +: 8] = (rq[i].size() != 0) ? rq[i][0] : 8'h00;
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) rq[i].delete();
    exp_q.delete();
    mptr = 0; seen = 0; last_id = -1; t_busy = -1;
    since_fall = 1000; low_run = 0; prev_int = 1'b1; prev_rdy = '0;
    tx_busy = 1'b0; req_valid = '0; req_data = '0;
  endtask

  // One clock of the world: observe DUT at negedge, update models, drive.
  task automatic cycle();
    logic [N-1:0] pv;
    int e, rid;
    ent_t en;
    @(negedge sys_clk);
    cyc++;
    pv = req_valid;
    since_fall++;
    if (t_busy >= 0) begin
      t_busy++;
      if (t_busy >= lat + frm) begin
        t_busy = -1;
        since_fall = 0;
      end
    end
    if (req_ready != '0) begin
      check("ready_onehot", 32'($onehot(req_ready)), 1);
      check("ready_1cyc", 32'(prev_rdy), 0);
      rid = -1;
      for (int i = 0; i < N; i++) if (req_ready[i]) rid = i;
      e = rr_pick(pv, mptr);
      check("grant_id", rid, e);
      check("cur_id_ack", 32'(cur_id), e);
      check_ok("gap_before_grant", since_fall >= GAP + 1, since_fall, GAP + 1);
      if (e >= 0 && rq[e].size() != 0) begin
`ifdef UART_ARB_TAG_EN
        if (!seen || last_id != e) exp_q.push_back('{8'hA0 | 8'(e), e, 1'b1});
        seen = 1; last_id = e;
`endif
        exp_q.push_back('{rq[e].pop_front(), e, 1'b0});
        mptr = (e + 1) % N;
      end
      ack_log.push_back(rid);
    end
    if (prev_int && !tx_int) begin
      sent_log.push_back(tx_data);
      check_ok("strobe_expected", exp_q.size() != 0, 0, 1);
      if (exp_q.size() != 0) begin
        en = exp_q.pop_front();
        check("tx_data", 32'(tx_data), 32'(en.b));
        check("cur_id_strobe", 32'(cur_id), en.id);
        if (tie0 && en.tag && exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (rnd_busy) begin
        lat = $urandom_range(1, 5);
        frm = $urandom_range(2, 20);
      end
      if (!tie0) t_busy = 0;
    end
    if (!prev_int && tx_int) begin
      check("strobe_width", low_run, 2);
      if (rise_cyc < 0) rise_cyc = cyc;
    end
    if (timeout_err && err_cyc < 0) err_cyc = cyc;
    low_run  = tx_int ? 0 : low_run + 1;
    prev_int = tx_int;
    prev_rdy = req_ready;
    tx_busy  = (t_busy >= lat && t_busy < lat + frm);
    drive_reqs();
  endtask

  task automatic run_idle(input int budget, input string name);
    int n;
    bit done;
    n = 0; done = 0;
    while (!done && n < budget) begin
      cycle();
      n++;
      done = all_empty() && exp_q.size() == 0 && t_busy < 0 && !arb_busy;
    end
    check_ok(name, done, n, budget);
  endtask

  task automatic do_reset();
    sys_rstn = 1'b0;
    model_clear();
    #1;
    check("rst_tx_int", 32'(tx_int), 1);
    check("rst_ready", 32'(req_ready), 0);
    check("rst_arb_busy", 32'(arb_busy), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_cur_id", 32'(cur_id), 0);
    check("rst_timeout", 32'(timeout_err), 0);
    repeat (3) @(negedge sys_clk);
    sys_rstn = 1'b1;
  endtask

  vec_t tbl[8];
  int   na;

  initial begin
    lat = 3; frm = 100; tie0 = 0; rnd_busy = 0; cyc = 0;
    rise_cyc = -1; err_cyc = -1;
    tbl[0] = '{4'b0001, 1, '{0, 0, 0, 0}};
    tbl[1] = '{4'b0101, 2, '{2, 0, 0, 0}};
    tbl[2] = '{4'b1111, 4, '{1, 2, 3, 0}};
    tbl[3] = '{4'b1001, 2, '{3, 0, 0, 0}};
    tbl[4] = '{4'b0010, 1, '{1, 0, 0, 0}};
    tbl[5] = '{4'b0011, 2, '{0, 1, 0, 0}};
    tbl[6] = '{4'b0100, 1, '{2, 0, 0, 0}};
    tbl[7] = '{4'b0101, 2, '{0, 2, 0, 0}};

    @(negedge sys_clk);
    do_reset();

    // single requester, two bytes back to back
    ack_log.delete(); sent_log.delete();
    rq[0].push_back(8'h5A); rq[0].push_back(8'hA5);
    run_idle(2000, "single_done");
    check("single_acks", ack_log.size(), 2);
    check("single_last", 32'(sent_log[sent_log.size()-1]), 32'h000000A5);

    // round robin from pointer 0
    do_reset();
    ack_log.delete();
    for (int i = 0; i < N; i++) begin
      rq[i].push_back(8'(8'h10 + i));
      rq[i].push_back(8'(8'h10 + i));
    end
    run_idle(5000, "rr_done");
    check("rr_count", ack_log.size(), 2 * N);
    for (int k = 0; k < 5; k++)
      if (k < ack_log.size()) check("rr_order", ack_log[k], k % N);

    // pointer table
    do_reset();
    for (int e = 0; e < 8; e++) begin
      ack_log.delete();
      for (int i = 0; i < N; i++)
        if (tbl[e].valid[i]) rq[i].push_back(8'(8'h20 + e * 4 + i));
      run_idle(4000, "tbl_done");
      check("tbl_n", ack_log.size(), tbl[e].n);
      na = (ack_log.size() < tbl[e].n) ? ack_log.size() : tbl[e].n;
      for (int k = 0; k < na; k++) check("tbl_id", ack_log[k], tbl[e].ids[k]);
    end

    // reset in the middle of a frame
    lat = 3; frm = 100;
    rq[2].push_back(8'hC3);
    for (int k = 0; k < 30; k++) cycle();
    check("pre_rst_busy", 32'(arb_busy), 1);
    check("pre_rst_txb", 32'(tx_busy), 1);
    do_reset();

    // transmitter that never answers
    tie0 = 1; rise_cyc = -1; err_cyc = -1;
    rq[1].push_back(8'h77);
    run_idle(2000, "to_done");
    check_ok("timeout_latency",
             err_cyc - rise_cyc >= TO && err_cyc - rise_cyc <= TO + 1,
             err_cyc - rise_cyc, TO);
    check("to_flag", 32'(timeout_err), 1);
    tie0 = 0; ack_log.delete(); sent_log.delete();
    rq[2].push_back(8'h88);
    run_idle(2000, "after_to_done");
    check("after_to_ack", ack_log.size(), 1);
    check("after_to_sent", 32'(sent_log[sent_log.size()-1]), 32'h88);
    check("to_sticky", 32'(timeout_err), 1);

`ifdef UART_ARB_TAG_EN
    begin
      logic [7:0] tag_exp[5];
      tag_exp = '{8'hA1, 8'h33, 8'h44, 8'hA3, 8'h55};
      do_reset();
      sent_log.delete();
      rq[1].push_back(8'h33); run_idle(2000, "tag_a");
      rq[1].push_back(8'h44); run_idle(2000, "tag_b");
      rq[3].push_back(8'h55); run_idle(2000, "tag_c");
      check("tag_len", sent_log.size(), 5);
      for (int k = 0; k < 5; k++)
        if (k < sent_log.size()) check("tag_seq", 32'(sent_log[k]), 32'(tag_exp[k]));
    end
`endif

    // random traffic against the model
    do_reset();
    rnd_busy = 1;
    lat = $urandom_range(1, 5); frm = $urandom_range(2, 20);
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        int r;
        r = $urandom_range(0, N - 1);
        if (rq[r].size() < 3) rq[r].push_back(8'($urandom));
      end
      cycle();
    end
    run_idle(20000, "rand_done");
    check("rand_no_timeout", 32'(timeout_err), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
